// File: rtl/axi_dma_pkg.sv
// rtl/axi_dma_pkg.sv - shared types and AXI constants for the DMA write path
package axi_dma_pkg;

  typedef enum logic [2:0] {
    IDLE,
    AW,
    W,
    B,
    DONE
  } state_t;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // AXI awsize encoding: log2 of bytes per beat
  function automatic logic [2:0] size_of(input int data_width);
    return 3'($clog2(data_width / 8));
  endfunction

endpackage

// File: rtl/axi_dma_write.sv
// rtl/axi_dma_write.sv - AXI4 write master draining a FWFT FIFO into INCR bursts
module axi_dma_write
  import axi_dma_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 8,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   start_addr,
  input  logic [LEN_WIDTH-1:0]    xfer_beats,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  input  logic [DATA_WIDTH-1:0]   fifo_rd_data,
  input  logic                    fifo_empty,
  output logic                    fifo_rd_en,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic [7:0]              awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wlast,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready
);

  localparam int BYTE_SHIFT = $clog2(DATA_WIDTH / 8);
  localparam logic [LEN_WIDTH-1:0] BURST_MAX = LEN_WIDTH'(BURST_LEN);

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [LEN_WIDTH-1:0]  remaining;
  logic [8:0]            burst_beats;
  logic [8:0]            beat_cnt;
  logic                  w_fire;
  logic                  resp_err;

  // awlen for the next burst: a full burst, or whatever is left
  function automatic logic [7:0] next_awlen(input logic [LEN_WIDTH-1:0] rem);
    logic [LEN_WIDTH-1:0] beats;
    beats = (rem >= BURST_MAX) ? BURST_MAX : rem;
    return 8'(beats - LEN_WIDTH'(1));
  endfunction

  assign awsize     = size_of(DATA_WIDTH);
  assign awburst    = AXI_BURST_INCR;
  assign wstrb      = '1;
  assign wdata      = fifo_rd_data;
  assign wvalid     = (state == W) && !fifo_empty;
  assign w_fire     = wvalid && wready;
  assign fifo_rd_en = w_fire;
  assign wlast      = (state == W) && (beat_cnt == burst_beats - 9'd1);
  assign resp_err   = (bresp == AXI_RESP_SLVERR) || (bresp == AXI_RESP_DECERR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      awvalid     <= 1'b0;
      awaddr      <= '0;
      awlen       <= '0;
      bready      <= 1'b0;
      addr_reg    <= '0;
      remaining   <= '0;
      burst_beats <= '0;
      beat_cnt    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy  <= 1'b1;
            error <= 1'b0;
            if (xfer_beats != '0) begin
              addr_reg  <= start_addr;
              remaining <= xfer_beats;
              awvalid   <= 1'b1;
              awaddr    <= start_addr;
              awlen     <= next_awlen(xfer_beats);
              state     <= AW;
            end else begin
              state <= DONE;
            end
          end
        end

        AW: begin
          if (awready) begin
            awvalid     <= 1'b0;
            burst_beats <= 9'(awlen) + 9'd1;
            beat_cnt    <= '0;
            state       <= W;
          end
        end

        W: begin
          if (w_fire) begin
            beat_cnt  <= beat_cnt + 9'd1;
            remaining <= remaining - LEN_WIDTH'(1);
            if (wlast) begin
              addr_reg <= addr_reg + (ADDR_WIDTH'(burst_beats) << BYTE_SHIFT);
              bready   <= 1'b1;
              state    <= B;
            end
          end
        end

        B: begin
          if (bvalid) begin
            bready <= 1'b0;
            // an error response abandons every remaining burst
            if (resp_err) begin
              error <= 1'b1;
              state <= DONE;
            end else if (remaining == '0) begin
              state <= DONE;
            end else begin
              awvalid <= 1'b1;
              awaddr  <= addr_reg;
              awlen   <= next_awlen(remaining);
              state   <= AW;
            end
          end
        end

        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
